// File: rtl/uart_pkg.sv
// Shared definitions for the 8-P-1 UART transmitter.
// Holds the frame state encoding, frame geometry constants and the
// parity helper used when a byte is accepted.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 11;

  // Even parity is the XOR of all data bits; odd parity is its inverse.
  function automatic logic uart_parity(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter for the UART transmitter.
// Counts 0..CLKS_PER_BIT-1 and wraps; restart_i holds it at zero.
// Ports:
//   clk       - system clock
//   rst_n     - asynchronous active-low reset
//   restart_i - force the count to zero on the next edge
//   count_o   - current count within the bit period
//   tc_o      - high in the last cycle of a bit period
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 434,
  localparam int CNT_W = $clog2(CLKS_PER_BIT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restart_i,
  output logic [CNT_W-1:0] count_o,
  output logic             tc_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             tc_s;

  assign tc_s    = (count_q == CNT_W'(CLKS_PER_BIT - 1));
  assign tc_o    = tc_s;
  assign count_o = count_q;

  // Next count: hold at zero on restart, wrap at terminal count.
  always_comb begin
    count_d = count_q;
    if (restart_i) begin
      count_d = '0;
    end else if (tc_s) begin
      count_d = '0;
    end else begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_parity_tx.sv
// 8-P-1 serial transmitter with a valid/ready byte interface.
// Frame: start(0), 8 data bits LSB first, parity, stop(1); each bit lasts
// CLKS_PER_BIT clocks. All outputs are registered and are computed from the
// next state, so they change exactly on the edge that enters a new bit.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   tx_data     - byte to send, sampled on acceptance
//   tx_valid    - source offers a byte
//   tx_ready    - transmitter idle, will accept on this edge
//   tx_serial   - serial line, idle high
//   tx_busy     - frame in progress
//   frame_done  - one-cycle pulse in the last clock of the stop bit
module uart_parity_tx
  import uart_pkg::*;
#(
  parameter int   CLKS_PER_BIT = 434,
  parameter logic PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_serial,
  output logic       tx_busy,
  output logic       frame_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  uart_state_e      state_q, state_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic             tx_serial_q, tx_serial_d;
  logic             tx_ready_q, tx_ready_d;
  logic             tx_busy_q, tx_busy_d;
  logic             frame_done_q, frame_done_d;

  logic             restart_s;
  logic             tc_s;
  logic [CNT_W-1:0] count_s;

  // The bit timer is parked at zero while idle so the start bit gets a full period.
  assign restart_s = (state_q == IDLE);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart_i(restart_s),
    .count_o  (count_s),
    .tc_o     (tc_s)
  );

  // Next-state, datapath and next-output logic.
  always_comb begin
    state_d      = state_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    tx_serial_d  = 1'b1;
    tx_ready_d   = 1'b0;
    tx_busy_d    = 1'b1;
    frame_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (tx_valid && tx_ready_q) begin
          state_d   = START;
          shift_d   = tx_data;
          parity_d  = uart_parity(tx_data, PARITY_ODD);
          bit_idx_d = 3'd0;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (tc_s) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (tc_s) begin
          // Index 7 is the last data bit; the index is never incremented past it.
          if (bit_idx_q == 3'(DATA_BITS - 1)) begin
            state_d = PARITY;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          state_d = DATA;
        end
      end
      PARITY: begin
        if (tc_s) begin
          state_d = STOP;
        end else begin
          state_d = PARITY;
        end
      end
      STOP: begin
        if (tc_s) begin
          state_d = IDLE;
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs follow the state being entered so they are registered yet on time.
    case (state_d)
      IDLE: begin
        tx_serial_d = 1'b1;
        tx_ready_d  = 1'b1;
        tx_busy_d   = 1'b0;
      end
      START:   tx_serial_d = 1'b0;
      DATA:    tx_serial_d = shift_d[bit_idx_d];
      PARITY:  tx_serial_d = parity_d;
      STOP:    tx_serial_d = 1'b1;
      default: tx_serial_d = 1'b1;
    endcase

    // The pulse is set one count early so it lands in the final stop-bit cycle.
    if ((state_q == STOP) && (count_s == CNT_W'(CLKS_PER_BIT - 2))) begin
      frame_done_d = 1'b1;
    end else begin
      frame_done_d = 1'b0;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'd0;
      parity_q     <= 1'b0;
      tx_serial_q  <= 1'b1;
      tx_ready_q   <= 1'b1;
      tx_busy_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      tx_serial_q  <= tx_serial_d;
      tx_ready_q   <= tx_ready_d;
      tx_busy_q    <= tx_busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign tx_serial  = tx_serial_q;
  assign tx_ready   = tx_ready_q;
  assign tx_busy    = tx_busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_parity_tx.sv
// Self-checking bench for uart_parity_tx. Two instances (even and odd parity)
// share one stimulus stream; a bit-slot model of the 8-P-1 frame gives the
// expected line level for every cycle of every frame.
module tb_uart_parity_tx;

  localparam int C         = 4;
  localparam int FRAME_CYC = 11 * C;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;

  logic ready_e, serial_e, busy_e, done_e;
  logic ready_o, serial_o, busy_o, done_o;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int rise_q[$];
  logic busy_prev = 1'b0;

  uart_parity_tx #(.CLKS_PER_BIT(C), .PARITY_ODD(1'b0)) dut_even (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(ready_e), .tx_serial(serial_e), .tx_busy(busy_e), .frame_done(done_e)
  );

  uart_parity_tx #(.CLKS_PER_BIT(C), .PARITY_ODD(1'b1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(ready_o), .tx_serial(serial_o), .tx_busy(busy_o), .frame_done(done_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Record the cycle of each frame start (busy rising) on the even instance.
  always @(negedge clk) begin
    if (busy_e && !busy_prev) rise_q.push_back(cyc);
    busy_prev = busy_e;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Line level of a given bit slot of the frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input logic odd, input int slot);
    int ones;
    ones = $countones(b);
    if (slot == 0) return 1'b0;
    else if (slot <= 8) return b[slot-1];
    else if (slot == 9) return logic'((ones % 2) == 1) ^ odd;
    else return 1'b1;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_serial_even"}, serial_e, 1);
    check_eq({tag, "_serial_odd"},  serial_o, 1);
    check_eq({tag, "_ready"},       ready_e,  1);
    check_eq({tag, "_ready_odd"},   ready_o,  1);
    check_eq({tag, "_busy"},        busy_e,   0);
    check_eq({tag, "_busy_odd"},    busy_o,   0);
    check_eq({tag, "_done"},        done_e,   0);
    check_eq({tag, "_done_odd"},    done_o,   0);
  endtask

  task automatic idle_cycle(input string tag);
    @(negedge clk);
    check_idle_outputs(tag);
  endtask

  // Called just after the accepting edge; checks every cycle of the frame.
  task automatic check_frame(input logic [7:0] b, input bit keep_valid,
                             input logic [7:0] next_data, input int poke_at,
                             input int abort_at);
    int busy_cnt;
    int done_cnt;
    int slot;
    busy_cnt = 0;
    done_cnt = 0;
    for (int j = 0; j < FRAME_CYC; j++) begin
      @(negedge clk);
      slot = j / C;
      check_eq("serial_even", serial_e, frame_bit(b, 1'b0, slot));
      check_eq("serial_odd",  serial_o, frame_bit(b, 1'b1, slot));
      check_eq("busy",        busy_e,   1);
      check_eq("ready",       ready_e,  0);
      check_eq("done_even",   done_e,   logic'(j == FRAME_CYC - 1));
      check_eq("done_odd",    done_o,   logic'(j == FRAME_CYC - 1));
      busy_cnt += int'(busy_e);
      done_cnt += int'(done_e);
      if (j == 0) begin
        if (keep_valid) tx_data = next_data;
        else tx_valid = 1'b0;
      end
      if (j == poke_at) begin
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
      end
      if (poke_at >= 0 && j == poke_at + 1) tx_valid = 1'b0;
      if (j == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        return;
      end
    end
    check_eq("busy_cycles", busy_cnt, FRAME_CYC);
    check_eq("done_pulses", done_cnt, 1);
  endtask

  // One idle cycle, then offer byte b for acceptance on the next edge.
  task automatic send(input logic [7:0] b, input int poke_at, input int abort_at);
    idle_cycle("pre_send");
    tx_valid = 1'b1;
    tx_data  = b;
    @(posedge clk);
    check_frame(b, 1'b0, 8'h00, poke_at, abort_at);
  endtask

  initial begin
    // Reset then idle.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    idle_cycle("in_reset");
    rst_n = 1'b1;
    repeat (20) idle_cycle("idle_after_reset");

    // Directed frames.
    send(8'hA5, -1, -1);
    send(8'h07, -1, -1);

    // Back-to-back with tx_valid held high.
    rise_q.delete();
    idle_cycle("pre_b2b");
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    @(posedge clk);
    check_frame(8'h00, 1'b1, 8'hFF, -1, -1);
    idle_cycle("b2b_gap");
    @(posedge clk);
    check_frame(8'hFF, 1'b0, 8'h00, -1, -1);
    check_eq("b2b_starts", rise_q.size(), 2);
    if (rise_q.size() == 2) check_eq("b2b_spacing", rise_q[1] - rise_q[0], FRAME_CYC + 1);

    // Input ignored while busy.
    send(8'h81, 10, -1);
    repeat (3) idle_cycle("after_poke");

    // Reset during DATA bit 3.
    send(8'h5A, -1, 4 * C + 1);
    tx_valid = 1'b0;
    repeat (2) idle_cycle("held_reset");
    rst_n = 1'b1;
    repeat (5) idle_cycle("after_abort");
    send(8'h01, -1, -1);

    // Randomized bytes with random idle gaps.
    for (int n = 0; n < 12; n++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      repeat (gap) idle_cycle("rand_gap");
      send(8'($urandom), -1, -1);
    end
    idle_cycle("final_idle");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_parity_tx.md
# uart_parity_tx

Serial transmitter that frames one byte per transaction as start bit, 8 data bits LSB-first, one parity bit and one stop bit (8-P-1). It consumes the parity bit our parity generator produces and is the stage directly downstream of it in the serial output path. It presents a valid/ready handshake to the byte source and drives a single idle-high serial line.

## Interface

- CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200); legal range 2..65535.
- PARITY_ODD, 0, 0 = even parity (parity bit = ^data), 1 = odd parity (parity bit = ~^data).

- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- tx_data  input  8  byte to send; sampled only on acceptance.
- tx_valid  input  1  source has a byte on tx_data.
- tx_ready  output  1  block can accept a byte this cycle.
- tx_serial  output  1  serial line, idle high.
- tx_busy  output  1  frame in progress.
- frame_done  output  1  one-cycle pulse in the last clock of the stop bit.

## Operation

- Reset values: tx_serial=1, tx_ready=1, tx_busy=0, frame_done=0, state IDLE, counters 0. Reset asserted mid-frame aborts it immediately. The line returns high asynchronously and the byte is discarded.
- State machine: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
- IDLE: tx_ready=1, tx_serial=1. Acceptance occurs when tx_valid && tx_ready at a rising edge. On acceptance:
  - latch tx_data into the shift register;
  - compute and register the parity bit from the latched byte;
  - go to START.
- START: tx_serial=0 for CLKS_PER_BIT cycles.
- DATA: bit index 0..7. Drive shift[index] for CLKS_PER_BIT cycles each, then increment the index. After index 7, go to PARITY.
- PARITY: drive the registered parity bit for CLKS_PER_BIT cycles.
- STOP: tx_serial=1 for CLKS_PER_BIT cycles. frame_done=1 in the final cycle, then go to IDLE.
- tx_ready=0 and tx_busy=1 in every state except IDLE. tx_valid and tx_data are ignored while busy. A source holding tx_valid high is accepted on the first IDLE cycle.
- Bit counter: counts 0..CLKS_PER_BIT-1 and is $clog2(CLKS_PER_BIT) bits wide. Terminal count advances the bit or state; the counter wraps to 0 on every bit boundary.
- Width rules:
  - bit index is 3 bits and wraps only via the DATA->PARITY transition;
  - parity is a single XOR-reduce of all 8 latched bits, inverted when PARITY_ODD=1.
- tx_serial, tx_ready, tx_busy and frame_done are all registered, with no combinational path from inputs to outputs.

## Timing

- Acceptance at edge k: tx_serial falls and tx_busy rises immediately after edge k.
- A frame occupies exactly 11*CLKS_PER_BIT cycles from edge k.
- frame_done is high for the single cycle ending at edge k+11*CLKS_PER_BIT. tx_ready is high after that edge.
- The earliest next acceptance is edge k+11*CLKS_PER_BIT+1. The minimum frame spacing is therefore 11*CLKS_PER_BIT+1 cycles, with at least one idle-high cycle between frames.
- Deassertion of rst_n takes effect at the next rising edge, with state IDLE.

## Structure

- Shared package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - constants DATA_BITS=8 and FRAME_BITS=11;
  - a parity function taking an 8-bit value and an odd/even flag.
- One sub-module, uart_bit_timer: a CLKS_PER_BIT counter with a restart input and a terminal-count output. The FSM, shift register and parity register stay in the top.

## Test plan

All scenarios use CLKS_PER_BIT=4.
- Reset then idle: hold rst_n=0 for 3 cycles, release -> tx_serial=1, tx_ready=1, tx_busy=0 and frame_done=0 for 20 cycles with tx_valid=0.
- Even parity frame: PARITY_ODD=0, send 0xA5 -> line sequence, each bit 4 cycles: 0, 1,0,1,0,0,1,0,1, 0, 1. Expect 44 busy cycles and one frame_done pulse.
- Odd-count byte: send 0x07 with PARITY_ODD=0 -> parity bit 1. With PARITY_ODD=1 -> parity bit 0. Data bits are 1,1,1,0,0,0,0,0.
- Back-to-back: tx_valid held high with 0x00 then 0xFF ->
  - exactly one idle-high cycle between frames;
  - second acceptance 45 cycles after the first;
  - parity 0 for both bytes.
- Ignored input while busy: pulse tx_valid with 0x3C at cycle 10 of a 0x81 frame -> the 0x81 frame is unchanged and 0x3C is never transmitted.
- Reset mid-frame: assert rst_n=0 during DATA bit 3 of 0x5A -> tx_serial=1 with no clock edge needed. After release, tx_ready=1 and there is no frame_done pulse. A new byte 0x01 then transmits correctly.
